// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Shares one external memory controller between an instruction-fetch port (I, read-only)
//   and a load/store port (D). One transaction is in flight at a time. Completion is tracked
//   through the controller's 2-bit state output, where 2'b00 means idle.
//
// Ports
//   clk, rst                         clock (rising edge), asynchronous active-low reset
//   i_req/i_addr/i_rd_ctrl           I request, held stable until i_gnt
//   i_gnt, i_done, i_rdata           I accept pulse, completion pulse, read data
//   d_req/d_addr/d_rd_ctrl/
//   d_wr_ctrl/d_wdata                D request, held stable until d_gnt; a write wins over a read
//   d_gnt, d_done, d_rdata           D accept pulse, completion pulse, read data
//   mem_rd_ctrl/mem_wr_ctrl/
//   mem_addr/mem_din                 controller command side
//   mem_dout, mem_state              controller read data and next-state
//   busy                             transaction in progress
//   err                              sticky timeout flag
//
// Parameters
//   STARVE_LIMIT  consecutive D grants, while I is waiting, before I is forced to win
//   TIMEOUT       WAIT cycles before a stuck transaction is aborted

module dram_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [63:0] i_addr,
  input  logic [2:0]  i_rd_ctrl,
  output logic        i_gnt,
  output logic        i_done,
  output logic [63:0] i_rdata,
  input  logic        d_req,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_rd_ctrl,
  input  logic [2:0]  d_wr_ctrl,
  input  logic [63:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [63:0] d_rdata,
  output logic [2:0]  mem_rd_ctrl,
  output logic [2:0]  mem_wr_ctrl,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_din,
  input  logic [63:0] mem_dout,
  input  logic [1:0]  mem_state,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic        owner_d, owner_d_n;   // 1 = D owns the current transaction
  logic        cap_rd, cap_rd_n;     // current transaction returns read data
  logic [3:0]  starve, starve_n;
  logic [7:0]  tcnt, tcnt_n;
  logic        pick_i;

  logic        i_gnt_n, d_gnt_n, i_done_n, d_done_n, busy_n, err_n;
  logic [63:0] i_rdata_n, d_rdata_n, mem_addr_n, mem_din_n;
  logic [2:0]  mem_rd_ctrl_n, mem_wr_ctrl_n;

  // State and every output are registered together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      owner_d     <= 1'b0;
      cap_rd      <= 1'b0;
      starve      <= '0;
      tcnt        <= '0;
      i_gnt       <= 1'b0;
      d_gnt       <= 1'b0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      mem_addr    <= '0;
      mem_din     <= '0;
      mem_rd_ctrl <= '0;
      mem_wr_ctrl <= '0;
    end else begin
      state       <= state_n;
      owner_d     <= owner_d_n;
      cap_rd      <= cap_rd_n;
      starve      <= starve_n;
      tcnt        <= tcnt_n;
      i_gnt       <= i_gnt_n;
      d_gnt       <= d_gnt_n;
      i_done      <= i_done_n;
      d_done      <= d_done_n;
      busy        <= busy_n;
      err         <= err_n;
      i_rdata     <= i_rdata_n;
      d_rdata     <= d_rdata_n;
      mem_addr    <= mem_addr_n;
      mem_din     <= mem_din_n;
      mem_rd_ctrl <= mem_rd_ctrl_n;
      mem_wr_ctrl <= mem_wr_ctrl_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n       = state;
    owner_d_n     = owner_d;
    cap_rd_n      = cap_rd;
    starve_n      = starve;
    tcnt_n        = tcnt;
    i_gnt_n       = 1'b0;
    d_gnt_n       = 1'b0;
    i_done_n      = 1'b0;
    d_done_n      = 1'b0;
    busy_n        = busy;
    err_n         = err;
    i_rdata_n     = i_rdata;
    d_rdata_n     = d_rdata;
    mem_addr_n    = mem_addr;
    mem_din_n     = mem_din;
    mem_rd_ctrl_n = mem_rd_ctrl;
    mem_wr_ctrl_n = mem_wr_ctrl;
    // I wins only when D is absent or I has waited through STARVE_LIMIT D grants
    pick_i        = i_req && (!d_req || (starve == STARVE_MAX));

    case (state)
      S_IDLE: begin
        if (!i_req || pick_i) begin
          starve_n = '0;
        end else if (d_req && (starve != STARVE_MAX)) begin
          starve_n = starve + 4'd1;
        end
        if (i_req || d_req) begin
          state_n = S_ISSUE;
          busy_n  = 1'b1;
          if (pick_i) begin
            owner_d_n     = 1'b0;
            cap_rd_n      = 1'b1;
            i_gnt_n       = 1'b1;
            mem_addr_n    = i_addr;
            mem_din_n     = '0;
            mem_rd_ctrl_n = i_rd_ctrl;
            mem_wr_ctrl_n = '0;
          end else begin
            owner_d_n  = 1'b1;
            d_gnt_n    = 1'b1;
            mem_addr_n = d_addr;
            mem_din_n  = d_wdata;
            if (d_wr_ctrl != 3'd0) begin
              cap_rd_n      = 1'b0;
              mem_rd_ctrl_n = '0;
              mem_wr_ctrl_n = d_wr_ctrl;
            end else begin
              cap_rd_n      = (d_rd_ctrl != 3'd0);
              mem_rd_ctrl_n = d_rd_ctrl;
              mem_wr_ctrl_n = '0;
            end
          end
        end
      end

      // Command stays on the bus until the controller leaves idle
      S_ISSUE: begin
        if (mem_state != 2'b00) begin
          state_n       = S_WAIT;
          tcnt_n        = '0;
          mem_rd_ctrl_n = '0;
          mem_wr_ctrl_n = '0;
        end
      end

      S_WAIT: begin
        if (mem_state == 2'b00) begin
          state_n = S_RESP;
          if (cap_rd) begin
            if (owner_d) d_rdata_n = mem_dout;
            else         i_rdata_n = mem_dout;
          end
          if (owner_d) d_done_n = 1'b1;
          else         i_done_n = 1'b1;
        end else if (tcnt == TO_LAST) begin
          // Abort: report completion with zeroed data and flag the error
          state_n = S_RESP;
          err_n   = 1'b1;
          if (owner_d) begin
            d_rdata_n = '0;
            d_done_n  = 1'b1;
          end else begin
            i_rdata_n = '0;
            i_done_n  = 1'b1;
          end
        end else begin
          tcnt_n = tcnt + 8'd1;
        end
      end

      S_RESP: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end

      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
